// File: rtl/caches_types_pkg.sv
// Shared cache/memory types: words, blocks, RAM status,
// plus the memory controller FSM and grant encodings.
package caches_types_pkg;

  localparam int DC_WORDS = 2;

  typedef logic [31:0] word_t;
  typedef word_t [DC_WORDS-1:0] dc_block_t;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic {
    ICACHE,
    DCACHE
  } grant_t;

  typedef enum logic [2:0] {
    IDLE,
    IFETCH,
    DRD,
    DWR,
    IRESP,
    DRESP
  } mc_state_t;

endpackage

// File: rtl/mc_arbiter.sv
// Two-way cache arbiter; a last-grant bit breaks ties
// so simultaneous requesters alternate.
module mc_arbiter
  import caches_types_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   ireq,
  input  logic   dreq,
  input  logic   take,
  output logic   gnt_valid,
  output grant_t gnt
);

  grant_t last_grant;

  always_comb begin
    gnt_valid = ireq | dreq;
    gnt = ICACHE;
    if (ireq && dreq)
      gnt = (last_grant == ICACHE) ? DCACHE : ICACHE;
    else if (dreq)
      gnt = DCACHE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_grant <= ICACHE;
    else if (take && gnt_valid)
      last_grant <= gnt;
  end

endmodule

// File: rtl/cache_mem_ctrl.sv
// Memory-side responder: serialises icache fills and
// dcache block fills/writebacks onto one RAM port.
module cache_mem_ctrl
  import caches_types_pkg::*;
#(
  parameter int DC_WORDS = 2,
  parameter int IC_WORDS = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  dc_block_t   dstore,
  output logic        dwait,
  output dc_block_t   dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate
);

  if (IC_WORDS != 1 || DC_WORDS != 2) begin : g_bad
    $error("cache_mem_ctrl: unsupported block size");
  end

  mc_state_t   state, nstate;
  logic        wcnt;
  logic [29:0] addr_q;
  dc_block_t   store_q;
  logic        gnt_valid;
  grant_t      gnt;
  logic        take;
  logic        acc;
  logic        last_w;
  logic        unused;

  assign unused = ^{iaddr[1:0], daddr[1:0]};
  assign take   = (state == IDLE);
  assign acc    = (ramstate == ACCESS);
  assign last_w = (wcnt == 1'(DC_WORDS - 1));
  assign iwait  = (state != IRESP);
  assign dwait  = (state != DRESP);

  mc_arbiter u_arb (
    .clk       (CLK),
    .rst       (RST),
    .ireq      (iREN),
    .dreq      (dREN | dWEN),
    .take      (take),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  always_comb begin
    nstate   = state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state)
      IDLE: begin
        if (gnt_valid) begin
          if (gnt == ICACHE) nstate = IFETCH;
          else if (dWEN)     nstate = DWR;
          else               nstate = DRD;
        end
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = {addr_q, 2'b00};
        if (acc) nstate = IRESP;
      end
      DRD: begin
        ramREN  = 1'b1;
        ramaddr = {addr_q[29:1], wcnt, 2'b00};
        if (acc && last_w) nstate = DRESP;
      end
      DWR: begin
        ramWEN   = 1'b1;
        ramaddr  = {addr_q[29:1], wcnt, 2'b00};
        ramstore = store_q[wcnt];
        if (acc && last_w) nstate = DRESP;
      end
      IRESP:   nstate = IDLE;
      DRESP:   nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      wcnt    <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      iload   <= '0;
      dload   <= '0;
    end else begin
      state <= nstate;
      if (state == IDLE && gnt_valid) begin
        addr_q  <= (gnt == ICACHE) ? iaddr[31:2]
                                   : daddr[31:2];
        store_q <= dstore;
        wcnt    <= 1'b0;
      end
      // Only ACCESS moves data or the word counter.
      if (acc) begin
        unique case (state)
          IFETCH: iload <= ramload;
          DRD: begin
            dload[wcnt] <= ramload;
            if (!last_w) wcnt <= wcnt + 1'b1;
          end
          DWR: begin
            if (!last_w) wcnt <= wcnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl with a small RAM
// model whose status can be forced to stall.
module tb_cache_mem_ctrl;
  import caches_types_pkg::*;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  dc_block_t   dstore;
  logic        dwait;
  dc_block_t   dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;

  cache_mem_ctrl #(.DC_WORDS(2), .IC_WORDS(1)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .dREN     (dREN),
    .dWEN     (dWEN),
    .daddr    (daddr),
    .dstore   (dstore),
    .dwait    (dwait),
    .dload    (dload),
    .ramREN   (ramREN),
    .ramWEN   (ramWEN),
    .ramaddr  (ramaddr),
    .ramstore (ramstore),
    .ramload  (ramload),
    .ramstate (ramstate)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [31:0] mem [0:1023];
  logic        init_done;
  logic        force_en;
  ramstate_t   force_val;

  always_comb begin
    ramstate = FREE;
    if (force_en)
      ramstate = force_val;
    else if (ramREN || ramWEN)
      ramstate = ACCESS;
  end

  assign ramload = mem[ramaddr[11:2]];

  always @(posedge CLK) begin
    if (!init_done) begin
      mem[10'h041] <= 32'hDEAD_BEEF;
      mem[10'h3C2] <= 32'h0000_0011;
      mem[10'h3C3] <= 32'h0000_0022;
    end else if (ramWEN && ramstate == ACCESS) begin
      mem[ramaddr[11:2]] <= ramstore;
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    logic        r;
  } acc_t;

  acc_t log_q[$];

  always @(posedge CLK) begin
    if (ramstate == ACCESS && (ramREN || ramWEN))
      log_q.push_back('{ramaddr, ramstore, ramWEN, ramREN});
  end

  int both_en;
  always @(negedge CLK) begin
    if (ramREN && ramWEN) both_en <= both_en + 1;
  end

  int checks;
  int failures;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic        iren;
    logic        dren;
    logic        dwen;
    logic [31:0] addr;
    logic [63:0] store;
    logic [63:0] exp_load;
    int          exp_lat;
  } vec_t;

  task automatic run_vec(input vec_t v, input int id);
    int          lat;
    bit          is_i;
    logic        other;
    logic [31:0] ea;
    logic [31:0] ew;
    int          nw;
    string       tag;
    tag  = $sformatf("v%0d", id);
    is_i = v.iren;
    log_q.delete();
    @(negedge CLK);
    iREN   = v.iren;
    dREN   = v.dren;
    dWEN   = v.dwen;
    iaddr  = v.addr;
    daddr  = v.addr;
    dstore = v.store;
    lat = 1;
    while ((is_i ? iwait : dwait) && lat < 50) begin
      @(posedge CLK);
      @(negedge CLK);
      lat++;
    end
    other = is_i ? dwait : iwait;
    chk({tag, "_latency"}, 64'(lat), 64'(v.exp_lat));
    chk({tag, "_other_wait"}, 64'(other), 64'd1);
    if (is_i)
      chk({tag, "_iload"}, 64'(iload), v.exp_load);
    else
      chk({tag, "_dload"}, dload, v.exp_load);
    nw = is_i ? 1 : 2;
    chk({tag, "_nacc"}, 64'(log_q.size()), 64'(nw));
    for (int k = 0; k < nw && k < log_q.size(); k++) begin
      ea = is_i ? {v.addr[31:2], 2'b00}
                : {v.addr[31:3], k[0], 2'b00};
      ew = k[0] ? v.store[63:32] : v.store[31:0];
      chk($sformatf("%s_addr%0d", tag, k),
          64'(log_q[k].a), 64'(ea));
      chk($sformatf("%s_dir%0d", tag, k),
          {62'd0, log_q[k].w, log_q[k].r},
          v.dwen ? 64'd2 : 64'd1);
      if (v.dwen) begin
        chk($sformatf("%s_wdata%0d", tag, k),
            64'(log_q[k].d), 64'(ew));
        chk($sformatf("%s_mem%0d", tag, k),
            64'(mem[ea[11:2]]), 64'(ew));
      end
    end
    iREN = 1'b0;
    dREN = 1'b0;
    dWEN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk({tag, "_wait_release"},
        64'({iwait, dwait}), 64'd3);
  endtask

  vec_t vecs[6];

  initial begin
    string       seq;
    int          cyc;
    bit          bad;
    int          pulses;
    logic [31:0] ha;
    logic [31:0] hd;

    checks    = 0;
    failures  = 0;
    both_en   = 0;
    init_done = 1'b0;
    force_en  = 1'b0;
    force_val = FREE;
    RST    = 1'b1;
    iREN   = 1'b1;
    dREN   = 1'b1;
    dWEN   = 1'b0;
    iaddr  = 32'h0000_0104;
    daddr  = 32'h0000_0F0C;
    dstore = '0;

    vecs[0] = '{1, 0, 0, 32'h0000_0104, 64'h0,
                64'h0000_0000_DEAD_BEEF, 3};
    vecs[1] = '{0, 1, 0, 32'h0000_0F0C, 64'h0,
                64'h0000_0022_0000_0011, 4};
    vecs[2] = '{0, 0, 1, 32'h0000_0040,
                64'h0000_BBBB_0000_AAAA,
                64'h0000_0022_0000_0011, 4};
    vecs[3] = '{0, 1, 1, 32'h0000_0080,
                64'h0000_0002_0000_0001,
                64'h0000_0022_0000_0011, 4};
    vecs[4] = '{1, 0, 0, 32'h0000_0042, 64'h0,
                64'h0000_0000_0000_AAAA, 3};
    vecs[5] = '{0, 1, 0, 32'h0000_0047, 64'h0,
                64'h0000_BBBB_0000_AAAA, 4};

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_waits", 64'({iwait, dwait}), 64'd3);
    chk("reset_loads", {dload[1] | dload[0], iload},
        64'd0);
    chk("reset_ram",
        64'({ramREN, ramWEN}) | 64'(ramaddr)
        | 64'(ramstore), 64'd0);
    init_done = 1'b1;

    @(negedge CLK);
    RST = 1'b0;
    seq = "";
    cyc = 0;
    bad = 1'b0;
    while (seq.len() < 4 && cyc < 100) begin
      @(posedge CLK);
      @(negedge CLK);
      cyc++;
      if (!iwait && !dwait) bad = 1'b1;
      if (!dwait) seq = {seq, "D"};
      if (!iwait) seq = {seq, "I"};
    end
    chk("arb_bound", 64'(cyc < 100), 64'd1);
    chk("arb_no_overlap", 64'(bad), 64'd0);
    chk("arb_order", 64'(seq == "DIDI"), 64'd1);
    if (seq != "DIDI")
      $display("arb order seen %s", seq);
    iREN = 1'b0;
    dREN = 1'b0;
    @(posedge CLK);
    @(negedge CLK);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    log_q.delete();
    @(negedge CLK);
    dWEN   = 1'b1;
    daddr  = 32'h0000_0200;
    dstore = 64'h0000_5555_0000_4444;
    @(posedge CLK);
    @(negedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    force_en  = 1'b1;
    force_val = BUSY;
    ha = ramaddr;
    hd = ramstore;
    chk("stall_addr", 64'(ha), 64'h204);
    chk("stall_data", 64'(hd), 64'h5555);
    bad = 1'b0;
    for (int c = 0; c < 7; c++) begin
      if (c == 5) force_val = ERROR;
      @(posedge CLK);
      @(negedge CLK);
      if (ramaddr !== ha || ramstore !== hd
          || ramWEN !== 1'b1 || ramREN !== 1'b0
          || dwait !== 1'b1)
        bad = 1'b1;
    end
    chk("stall_hold", 64'(bad), 64'd0);
    chk("stall_mem_untouched",
        64'(mem[10'h081] === 32'h5555), 64'd0);
    force_en = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk("stall_dwait_pulse", 64'(dwait), 64'd0);
    chk("stall_mem", 64'(mem[10'h081]), 64'h5555);
    dWEN = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(posedge CLK);
      @(negedge CLK);
      if (!dwait) pulses++;
    end
    chk("stall_single_pulse", 64'(pulses), 64'd0);

    @(negedge CLK);
    dREN  = 1'b1;
    daddr = 32'h0000_0F0C;
    @(posedge CLK);
    @(negedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("rst_mid_addr", 64'(ramaddr), 64'hF0C);
    RST = 1'b1;
    #1;
    chk("rst_mid_waits", 64'({iwait, dwait}), 64'd3);
    chk("rst_mid_loads", {dload[1] | dload[0], iload},
        64'd0);
    chk("rst_mid_ram",
        64'({ramREN, ramWEN}) | 64'(ramaddr), 64'd0);
    dREN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    run_vec(vecs[0], 6);

    chk("never_both_en", 64'(both_en), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=done");
    $fatal(1, "timeout");
  end

endmodule
